kv_cache_tag_ctrl: RTL and testbench
====================================

# kv_cache_tag_ctrl

Tag-lookup and miss-handling controller for the 4-way set-associative cache. It sits directly upstream of the LRU replacement block. It holds the tag/valid arrays, resolves hit/miss per request, and drives the LRU with hit way and set index. It consumes the LRU kill mask to pick a victim on a miss, then sequences a line refill over a valid/ready request plus a done strobe.

## Interface
Parameters:
- WAY_NUM, 4, number of ways
- LINE_NUM, 64, total lines; SETS = LINE_NUM/WAY_NUM
- ADDR_WIDTH, 32, request address width
- LINE_BYTES, 16, bytes per line; OFS_W = clog2(LINE_BYTES), IDX_W = clog2(SETS), TAG_W = ADDR_WIDTH-IDX_W-OFS_W

Ports (one clock; reset is asynchronous and active-low):
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_req_valid  in  1  lookup request
- o_req_ready  out  1  request accepted when valid&ready
- i_req_addr  in  ADDR_WIDTH  byte address; index = [OFS_W+:IDX_W], tag = upper TAG_W bits
- o_resp_valid  out  1  one-cycle response strobe
- o_resp_hit  out  1  1 = hit, 0 = completed after refill
- o_resp_way  out  WAY_NUM  one-hot way now holding the line
- o_lru_en  out  1  LRU update enable for this cycle
- o_lru_hitway  out  WAY_NUM  one-hot hit way; all-zero on miss
- o_lru_index  out  IDX_W  set index presented to LRU
- i_lru_killmask  in  WAY_NUM  LRU victim mask, combinational on o_lru_index
- o_refill_valid  out  1  refill request
- i_refill_ready  in  1  refill accepted
- o_refill_addr  out  ADDR_WIDTH  line-aligned address (offset bits zero)
- i_refill_done  in  1  one-cycle pulse: line data written
- i_flush  in  1  invalidate-all request (pulse or level)

## Operation
- Arrays: tag[SETS][WAY_NUM] (TAG_W), valid[SETS][WAY_NUM], flip-flop based.
- FSM states:
  - IDLE: o_req_ready=1 unless a flush is pending. Pending flush has priority: go to FLUSH, request not accepted. On accept, latch addr and go to LOOKUP.
  - LOOKUP: hitvec[w] = valid[idx][w] & (tag[idx][w]==tag). o_lru_en=1, o_lru_index=idx, o_lru_hitway=hitvec.
    - Hit: o_resp_valid=1, o_resp_hit=1, o_resp_way=hitvec; go to IDLE.
    - Miss: latch victim; go to MISS_REQ.
  - MISS_REQ: o_refill_valid=1 with o_refill_addr = {tag,idx,0}, held stable until i_refill_ready; then go to MISS_WAIT. If i_refill_done arrives in the same cycle as ready, go directly to the fill action.
  - MISS_WAIT: on i_refill_done, write tag[idx][victim]=tag and valid[idx][victim]=1. Pulse o_resp_valid, o_resp_hit=0, o_resp_way=victim; go to IDLE.
  - FLUSH: a counter walks sets 0..SETS-1, clearing valid[set][*] at 1 set/cycle; return to IDLE after set SETS-1. Tags are not cleared.
- Victim selection:
  - If any way in the set is invalid, use the lowest-numbered invalid way.
  - Otherwise use the lowest set bit of i_lru_killmask.
  - If the killmask is all-zero, use way WAY_NUM-1.
- Multiple hits (corruption) resolve to the lowest set bit; o_resp_way is always one-hot.
- i_flush asserted in any state sets flush_pending. It is cleared on entry to FLUSH. A miss in progress completes first.
- o_lru_en=0 and o_lru_hitway=0 outside LOOKUP; o_lru_index holds the last latched index.

## Timing
- Reset values: state IDLE, all valid=0, flush_pending=0, o_req_ready=1, all other outputs 0.
- Reset mid-miss aborts the refill at once: o_refill_valid drops asynchronously.
- Hit latency: accept at cycle N, response at N+1, next accept at N+2. Sustained throughput is 1 request / 2 cycles.
- Miss latency: accept N, LOOKUP N+1, o_refill_valid from N+2. Response is the cycle of i_refill_done, or the cycle after it if done arrives in MISS_REQ with ready.
- i_refill_done outside MISS_REQ/MISS_WAIT is ignored.
- Flush: SETS cycles in FLUSH; o_req_ready returns the cycle after the last set is cleared.
- Index/tag slicing is fixed-width; no wrap: flush counter stops at SETS-1.

## Test plan
- Cold miss: after reset, read 0x0000_1230 (idx 3) -> refill addr 0x0000_1230, victim way0 (lowest invalid), resp_hit=0, way=4'b0001.
- Hit after fill: reread 0x0000_123C -> response at N+1, resp_hit=1, way=4'b0001, o_lru_hitway=4'b0001, o_lru_index=3.
- Full set, LRU victim: fill idx 3 in all 4 ways with distinct tags, killmask=4'b0100 -> victim way2, then reread hits way2. With killmask=0, victim is way3.
- Refill backpressure: hold i_refill_ready=0 for 5 cycles -> o_refill_valid and addr stable throughout; response follows done.
- Flush: i_flush during a MISS_WAIT -> miss completes, then 16 FLUSH cycles with o_req_ready=0. A subsequent read of a previously hitting address misses.
- Async reset mid-MISS_REQ -> all outputs 0 immediately, o_req_ready=1 after release, prior lines miss.

Source files
------------

// File: rtl/kv_cache_tag_ctrl.sv
// kv_cache_tag_ctrl: tag/valid arrays, hit/miss resolution,
// victim choice and line refill / flush sequencing for a set-assoc cache.
//
// Ports:
//   i_clk, i_rstn          clock, async active-low reset
//   i_req_valid/o_req_ready, i_req_addr   lookup request handshake
//   o_resp_valid/hit/way   one-cycle response, one-hot way
//   o_lru_en/hitway/index  LRU update for the looked-up set
//   i_lru_killmask         LRU victim mask (comb on o_lru_index)
//   o_refill_valid/addr, i_refill_ready, i_refill_done   line refill
//   i_flush                invalidate-all request
module kv_cache_tag_ctrl #(
   parameter int WAY_NUM    = 4,
   parameter int LINE_NUM   = 64,
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_BYTES = 16,
   localparam int SETS  = LINE_NUM / WAY_NUM,
   localparam int OFS_W = $clog2(LINE_BYTES),
   localparam int IDX_W = $clog2(SETS),
   localparam int TAG_W = ADDR_WIDTH - IDX_W - OFS_W
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   output logic                  o_resp_valid,
   output logic                  o_resp_hit,
   output logic [WAY_NUM-1:0]    o_resp_way,
   output logic                  o_lru_en,
   output logic [WAY_NUM-1:0]    o_lru_hitway,
   output logic [IDX_W-1:0]      o_lru_index,
   input  logic [WAY_NUM-1:0]    i_lru_killmask,
   output logic                  o_refill_valid,
   input  logic                  i_refill_ready,
   output logic [ADDR_WIDTH-1:0] o_refill_addr,
   input  logic                  i_refill_done,
   input  logic                  i_flush
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_MISS_REQ,
      S_MISS_WAIT,
      S_FILL,
      S_FLUSH
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
      {{(ADDR_WIDTH-OFS_W){1'b1}}, {OFS_W{1'b0}}};
   localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SETS - 1);

   state_t                  state_q;
   state_t                  state_d;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [WAY_NUM-1:0]      victim_q;
   logic                    flush_pend_q;
   logic [IDX_W-1:0]        flush_cnt_q;
   logic [WAY_NUM-1:0]      valid_q [SETS];
   logic [TAG_W-1:0]        tag_q   [SETS][WAY_NUM];

   logic [TAG_W-1:0]        req_tag;
   logic [IDX_W-1:0]        req_idx;
   logic [WAY_NUM-1:0]      set_valid;
   logic [WAY_NUM-1:0]      hit_vec;
   logic [WAY_NUM-1:0]      hit_oh;
   logic [WAY_NUM-1:0]      victim_d;
   logic                    is_hit;
   logic                    accept;
   logic                    fill;
   logic                    flush_last;

   // One-hot of the lowest set bit; zero in, zero out.
   function automatic logic [WAY_NUM-1:0] low1(
      input logic [WAY_NUM-1:0] v
   );
      logic [WAY_NUM-1:0] r;
      r = '0;
      for (int i = WAY_NUM - 1; i >= 0; i--) begin
         if (v[i]) begin
            r    = '0;
            r[i] = 1'b1;
         end
      end
      return r;
   endfunction

   assign req_tag   = addr_q[ADDR_WIDTH-1 -: TAG_W];
   assign req_idx   = addr_q[OFS_W +: IDX_W];
   assign set_valid = valid_q[req_idx];

   always_comb begin
      hit_vec = '0;
      for (int w = 0; w < WAY_NUM; w++) begin
         hit_vec[w] = set_valid[w] &&
                      (tag_q[req_idx][w] == req_tag);
      end
   end

   // A corrupted set with several matching ways still yields one way.
   assign hit_oh = low1(hit_vec);
   assign is_hit = |hit_vec;

   // Free ways are consumed before the LRU is asked to evict.
   always_comb begin
      victim_d = '0;
      if (|(~set_valid)) begin
         victim_d = low1(~set_valid);
      end else if (|i_lru_killmask) begin
         victim_d = low1(i_lru_killmask);
      end else begin
         victim_d[WAY_NUM-1] = 1'b1;
      end
   end

   assign accept = (state_q == S_IDLE) && !flush_pend_q &&
                   i_req_valid;
   assign fill   = ((state_q == S_MISS_WAIT) && i_refill_done) ||
                   (state_q == S_FILL);
   assign flush_last = (flush_cnt_q == LAST_SET);

   // State register.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (flush_pend_q) begin
               state_d = S_FLUSH;
            end else if (i_req_valid) begin
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            state_d = is_hit ? S_IDLE : S_MISS_REQ;
         end
         S_MISS_REQ: begin
            if (i_refill_ready) begin
               state_d = i_refill_done ? S_FILL : S_MISS_WAIT;
            end
         end
         S_MISS_WAIT: begin
            if (i_refill_done) begin
               state_d = S_IDLE;
            end
         end
         S_FILL: begin
            state_d = S_IDLE;
         end
         S_FLUSH: begin
            if (flush_last) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output logic.
   always_comb begin
      o_req_ready    = 1'b0;
      o_resp_valid   = 1'b0;
      o_resp_hit     = 1'b0;
      o_resp_way     = '0;
      o_lru_en       = 1'b0;
      o_lru_hitway   = '0;
      o_refill_valid = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            o_req_ready = !flush_pend_q;
         end
         S_LOOKUP: begin
            o_lru_en     = 1'b1;
            o_lru_hitway = hit_oh;
            if (is_hit) begin
               o_resp_valid = 1'b1;
               o_resp_hit   = 1'b1;
               o_resp_way   = hit_oh;
            end
         end
         S_MISS_REQ: begin
            o_refill_valid = 1'b1;
         end
         S_MISS_WAIT: begin
            if (i_refill_done) begin
               o_resp_valid = 1'b1;
               o_resp_way   = victim_q;
            end
         end
         S_FILL: begin
            o_resp_valid = 1'b1;
            o_resp_way   = victim_q;
         end
         S_FLUSH: begin
            o_req_ready = 1'b0;
         end
         default: begin
            o_req_ready = 1'b0;
         end
      endcase
   end

   assign o_lru_index   = req_idx;
   assign o_refill_addr = addr_q & LINE_MASK;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         addr_q <= '0;
      end else if (accept) begin
         addr_q <= i_req_addr;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         victim_q <= '0;
      end else if ((state_q == S_LOOKUP) && !is_hit) begin
         victim_q <= victim_d;
      end
   end

   // A pending flush in IDLE always enters FLUSH, so IDLE clears it.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         flush_pend_q <= 1'b0;
      end else if (i_flush) begin
         flush_pend_q <= 1'b1;
      end else if (state_q == S_IDLE) begin
         flush_pend_q <= 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         flush_cnt_q <= '0;
      end else if (state_q == S_FLUSH) begin
         flush_cnt_q <= flush_last ? '0 : flush_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
         end
      end else if (state_q == S_FLUSH) begin
         valid_q[flush_cnt_q] <= '0;
      end else if (fill) begin
         valid_q[req_idx] <= set_valid | victim_q;
      end
   end

   // Tags need no reset: a way is only consulted while valid.
   always_ff @(posedge i_clk) begin
      if (fill) begin
         for (int w = 0; w < WAY_NUM; w++) begin
            if (victim_q[w]) begin
               tag_q[req_idx][w] <= req_tag;
            end
         end
      end
   end

endmodule

// File: tb/tb_kv_cache_tag_ctrl.sv
// tb_kv_cache_tag_ctrl: directed checks of lookup, refill,
// victim choice, backpressure, flush and async reset.
module tb_kv_cache_tag_ctrl;

   logic        i_clk = 1'b0;
   logic        i_rstn = 1'b0;
   logic        i_req_valid = 1'b0;
   logic        o_req_ready;
   logic [31:0] i_req_addr = '0;
   logic        o_resp_valid;
   logic        o_resp_hit;
   logic [3:0]  o_resp_way;
   logic        o_lru_en;
   logic [3:0]  o_lru_hitway;
   logic [3:0]  o_lru_index;
   logic [3:0]  i_lru_killmask = '0;
   logic        o_refill_valid;
   logic        i_refill_ready = 1'b0;
   logic [31:0] o_refill_addr;
   logic        i_refill_done = 1'b0;
   logic        i_flush = 1'b0;

   int checks = 0;
   int errors = 0;

   kv_cache_tag_ctrl dut (
      .i_clk          (i_clk),
      .i_rstn         (i_rstn),
      .i_req_valid    (i_req_valid),
      .o_req_ready    (o_req_ready),
      .i_req_addr     (i_req_addr),
      .o_resp_valid   (o_resp_valid),
      .o_resp_hit     (o_resp_hit),
      .o_resp_way     (o_resp_way),
      .o_lru_en       (o_lru_en),
      .o_lru_hitway   (o_lru_hitway),
      .o_lru_index    (o_lru_index),
      .i_lru_killmask (i_lru_killmask),
      .o_refill_valid (o_refill_valid),
      .i_refill_ready (i_refill_ready),
      .o_refill_addr  (o_refill_addr),
      .i_refill_done  (i_refill_done),
      .i_flush        (i_flush)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_miss(input string nm, input logic [31:0] a,
                          input logic [3:0] km, input logic [3:0] way);
      cyc();
      i_req_valid = 1'b1;
      i_req_addr  = a;
      #1 chk({nm, ".rdy"}, o_req_ready, 1);
      cyc();
      i_req_valid    = 1'b0;
      i_lru_killmask = km;
      #1;
      chk({nm, ".lru_en"}, o_lru_en, 1);
      chk({nm, ".lru_hw"}, o_lru_hitway, 0);
      chk({nm, ".lru_idx"}, o_lru_index, a[7:4]);
      chk({nm, ".no_resp"}, o_resp_valid, 0);
      cyc();
      i_lru_killmask = '0;
      #1;
      chk({nm, ".rf_v"}, o_refill_valid, 1);
      chk({nm, ".rf_a"}, o_refill_addr, a & 32'hFFFF_FFF0);
      i_refill_ready = 1'b1;
      cyc();
      i_refill_ready = 1'b0;
      i_refill_done  = 1'b1;
      #1;
      chk({nm, ".resp_v"}, o_resp_valid, 1);
      chk({nm, ".resp_hit"}, o_resp_hit, 0);
      chk({nm, ".resp_way"}, o_resp_way, way);
      cyc();
      i_refill_done = 1'b0;
   endtask

   task automatic do_hit(input string nm, input logic [31:0] a,
                         input logic [3:0] way);
      cyc();
      i_req_valid = 1'b1;
      i_req_addr  = a;
      #1 chk({nm, ".rdy"}, o_req_ready, 1);
      cyc();
      i_req_valid = 1'b0;
      #1;
      chk({nm, ".resp_v"}, o_resp_valid, 1);
      chk({nm, ".resp_hit"}, o_resp_hit, 1);
      chk({nm, ".resp_way"}, o_resp_way, way);
      chk({nm, ".lru_hw"}, o_lru_hitway, way);
      chk({nm, ".lru_idx"}, o_lru_index, a[7:4]);
      chk({nm, ".lru_en"}, o_lru_en, 1);
      cyc();
      #1;
      chk({nm, ".rdy2"}, o_req_ready, 1);
      chk({nm, ".resp_off"}, o_resp_valid, 0);
   endtask

   initial begin
      #2;
      chk("rst.rdy", o_req_ready, 1);
      chk("rst.resp_v", o_resp_valid, 0);
      chk("rst.resp_way", o_resp_way, 0);
      chk("rst.rf_v", o_refill_valid, 0);
      chk("rst.rf_a", o_refill_addr, 0);
      chk("rst.lru_en", o_lru_en, 0);
      chk("rst.lru_hw", o_lru_hitway, 0);
      chk("rst.lru_idx", o_lru_index, 0);
      #10 i_rstn = 1'b1;

      do_miss("cold", 32'h0000_1230, 4'b0000, 4'b0001);
      do_hit("hit0", 32'h0000_123C, 4'b0001);
      do_miss("w1", 32'h0000_2230, 4'b0000, 4'b0010);
      do_miss("w2", 32'h0000_3230, 4'b0000, 4'b0100);
      do_miss("w3", 32'h0000_4230, 4'b0000, 4'b1000);
      do_miss("lru", 32'h0000_5230, 4'b0100, 4'b0100);
      do_hit("hit2", 32'h0000_5230, 4'b0100);
      do_miss("km0", 32'h0000_6230, 4'b0000, 4'b1000);
      do_hit("hitw0", 32'h0000_1234, 4'b0001);
      do_hit("hitw1", 32'h0000_2230, 4'b0010);
      do_miss("evict", 32'h0000_3230, 4'b0010, 4'b0010);

      // Stray done in IDLE produces nothing.
      cyc();
      i_refill_done = 1'b1;
      #1 chk("stray.resp_v", o_resp_valid, 0);
      cyc();
      i_refill_done = 1'b0;
      #1 chk("stray.rdy", o_req_ready, 1);

      // Refill backpressure, then ready+done together.
      cyc();
      i_req_valid = 1'b1;
      i_req_addr  = 32'h0000_7750;
      cyc();
      i_req_valid = 1'b0;
      cyc();
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp.rf_v", o_refill_valid, 1);
         chk("bp.rf_a", o_refill_addr, 32'h0000_7750);
         cyc();
      end
      i_refill_ready = 1'b1;
      i_refill_done  = 1'b1;
      #1;
      chk("bp.rf_v_last", o_refill_valid, 1);
      chk("bp.early", o_resp_valid, 0);
      cyc();
      i_refill_ready = 1'b0;
      i_refill_done  = 1'b0;
      #1;
      chk("bp.resp_v", o_resp_valid, 1);
      chk("bp.resp_hit", o_resp_hit, 0);
      chk("bp.resp_way", o_resp_way, 4'b0001);
      cyc();
      #1 chk("bp.rdy", o_req_ready, 1);
      do_hit("bp_hit", 32'h0000_7758, 4'b0001);

      // Flush raised while a miss waits for its data.
      cyc();
      i_req_valid = 1'b1;
      i_req_addr  = 32'h0000_8880;
      cyc();
      i_req_valid = 1'b0;
      cyc();
      #1 chk("fl.rf_v", o_refill_valid, 1);
      i_refill_ready = 1'b1;
      cyc();
      i_refill_ready = 1'b0;
      i_flush        = 1'b1;
      cyc();
      i_flush       = 1'b0;
      i_refill_done = 1'b1;
      #1;
      chk("fl.resp_v", o_resp_valid, 1);
      chk("fl.resp_way", o_resp_way, 4'b0001);
      cyc();
      i_refill_done = 1'b0;
      #1 chk("fl.pend_rdy", o_req_ready, 0);
      for (int i = 0; i < 16; i++) begin
         cyc();
         #1 chk("fl.busy_rdy", o_req_ready, 0);
      end
      cyc();
      #1 chk("fl.done_rdy", o_req_ready, 1);
      do_miss("fl_re", 32'h0000_1230, 4'b0000, 4'b0001);
      do_miss("fl_re2", 32'h0000_7750, 4'b0000, 4'b0001);

      // Async reset while the refill request is outstanding.
      cyc();
      i_req_valid = 1'b1;
      i_req_addr  = 32'h0000_9990;
      cyc();
      i_req_valid = 1'b0;
      cyc();
      #1 chk("ar.rf_v_pre", o_refill_valid, 1);
      #2 i_rstn = 1'b0;
      #1;
      chk("ar.rf_v", o_refill_valid, 0);
      chk("ar.rf_a", o_refill_addr, 0);
      chk("ar.resp_v", o_resp_valid, 0);
      chk("ar.lru_en", o_lru_en, 0);
      chk("ar.lru_idx", o_lru_index, 0);
      #10 i_rstn = 1'b1;
      cyc();
      #1 chk("ar.rdy", o_req_ready, 1);
      do_miss("ar_re", 32'h0000_1230, 4'b0000, 4'b0001);
      do_hit("ar_hit", 32'h0000_1230, 4'b0001);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
